// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the character LCD driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT_NIB,
    S_INIT_CMD,
    S_FRAME,
    S_IDLE
  } lcd_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_EHI,
    W_HOLD,
    W_GAP,
    W_WAIT
  } wr_state_t;

  localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ADDR_ROW0 = 8'h80;
  localparam logic [7:0] LCD_ADDR_ROW1 = 8'hC0;

  // Counters only ever reach (cycles - 1), so $clog2 of the largest delay suffices.
  function automatic int wait_cnt_width(input int a, input int b, input int c,
                                        input int d, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_4BIT;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY_INC;
      default: return LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Emits one nibble or one full byte on the 4-bit LCD bus with SETUP/EHI/HOLD
// framing, then holds off for the post-write settle time before pulsing done.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC       = 750_000,
  parameter int INIT_NIB_WAIT_CYC = 205_000,
  parameter int E_PULSE_CYC       = 12,
  parameter int NIBBLE_GAP_CYC    = 50,
  parameter int CMD_WAIT_CYC      = 2_000,
  parameter int CLEAR_WAIT_CYC    = 82_000
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_byte,
  input  logic       rs,
  input  logic       nibble_only,
  output logic       busy,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d
);

  localparam int CW = wait_cnt_width(POWERUP_CYC, INIT_NIB_WAIT_CYC, E_PULSE_CYC,
                                     NIBBLE_GAP_CYC, CMD_WAIT_CYC, CLEAR_WAIT_CYC);

  wr_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] wait_last_reg;
  logic [3:0]    low_nib_reg;
  logic          second_reg;
  logic          nib_only_reg;

  assign busy = (state_reg != W_IDLE);

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_reg     <= W_IDLE;
      cnt_reg       <= '0;
      wait_last_reg <= '0;
      low_nib_reg   <= '0;
      second_reg    <= 1'b0;
      nib_only_reg  <= 1'b0;
      done          <= 1'b0;
      lcd_e         <= 1'b0;
      lcd_rs        <= 1'b0;
      lcd_d         <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        W_IDLE: begin
          if (start) begin
            state_reg    <= W_SETUP;
            lcd_d        <= data_byte[7:4];
            lcd_rs       <= rs;
            low_nib_reg  <= data_byte[3:0];
            second_reg   <= 1'b0;
            nib_only_reg <= nibble_only;
            if (nibble_only)
              wait_last_reg <= CW'(INIT_NIB_WAIT_CYC - 1);
            else if (!rs && data_byte == LCD_CLEAR)
              wait_last_reg <= CW'(CLEAR_WAIT_CYC - 1);
            else
              wait_last_reg <= CW'(CMD_WAIT_CYC - 1);
          end
        end
        W_SETUP: begin
          state_reg <= W_EHI;
          lcd_e     <= 1'b1;
          cnt_reg   <= '0;
        end
        W_EHI: begin
          if (cnt_reg == CW'(E_PULSE_CYC - 1)) begin
            state_reg <= W_HOLD;
            lcd_e     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        W_HOLD: begin
          cnt_reg   <= '0;
          state_reg <= (second_reg || nib_only_reg) ? W_WAIT : W_GAP;
        end
        W_GAP: begin
          // D only ever changes on entry to SETUP, never during the gap itself.
          if (cnt_reg == CW'(NIBBLE_GAP_CYC - 1)) begin
            state_reg  <= W_SETUP;
            lcd_d      <= low_nib_reg;
            second_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        W_WAIT: begin
          if (cnt_reg == wait_last_reg) begin
            state_reg <= W_IDLE;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// Initialises a 2x16 HD44780 LCD in 4-bit mode and refreshes both rows from a
// per-frame snapshot. Define LCD_DIRTY_SKIP_EN to skip frames whose text is unchanged.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC       = 750_000,
  parameter int INIT_NIB_WAIT_CYC = 205_000,
  parameter int E_PULSE_CYC       = 12,
  parameter int NIBBLE_GAP_CYC    = 50,
  parameter int CMD_WAIT_CYC      = 2_000,
  parameter int CLEAR_WAIT_CYC    = 82_000
) (
  input  logic         clk_50MHz,
  input  logic         reset_n,
  input  logic [127:0] row_A,
  input  logic [127:0] row_B,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [3:0]   LCD_D,
  output logic         frame_done
);

  localparam int CW = wait_cnt_width(POWERUP_CYC, INIT_NIB_WAIT_CYC, E_PULSE_CYC,
                                     NIBBLE_GAP_CYC, CMD_WAIT_CYC, CLEAR_WAIT_CYC);

  lcd_state_t    state_reg;
  logic [CW-1:0] pwr_cnt_reg;
  logic [1:0]    step_reg;
  logic [3:0]    col_reg;
  logic          row_sel_reg;
  logic          data_phase_reg;
  logic          snapped_reg;
  logic          pending_reg;
  logic [127:0]  snap_a_reg;
  logic [127:0]  snap_b_reg;
  logic          wr_start_reg;
  logic [7:0]    wr_byte_reg;
  logic          wr_rs_reg;
  logic          wr_nib_only_reg;
  logic          wr_busy;
  logic          wr_done;
  logic [7:0]    frame_byte;
  logic          frame_rs;
`ifdef LCD_DIRTY_SKIP_EN
  logic          frame_sent_reg;
`endif

  assign LCD_RW = 1'b0;

  // Column 0 sits in the top byte, so the slice base is (15 - col) * 8.
  always_comb begin
    frame_rs = data_phase_reg;
    if (!data_phase_reg)
      frame_byte = row_sel_reg ? LCD_ADDR_ROW1 : LCD_ADDR_ROW0;
    else if (row_sel_reg)
      frame_byte = snap_b_reg[{~col_reg, 3'b000} +: 8];
    else
      frame_byte = snap_a_reg[{~col_reg, 3'b000} +: 8];
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_reg       <= S_POWERUP;
      pwr_cnt_reg     <= '0;
      step_reg        <= '0;
      col_reg         <= '0;
      row_sel_reg     <= 1'b0;
      data_phase_reg  <= 1'b0;
      snapped_reg     <= 1'b0;
      pending_reg     <= 1'b0;
      snap_a_reg      <= '0;
      snap_b_reg      <= '0;
      wr_start_reg    <= 1'b0;
      wr_byte_reg     <= '0;
      wr_rs_reg       <= 1'b0;
      wr_nib_only_reg <= 1'b0;
      frame_done      <= 1'b0;
`ifdef LCD_DIRTY_SKIP_EN
      frame_sent_reg  <= 1'b0;
`endif
    end else begin
      wr_start_reg <= 1'b0;
      frame_done   <= 1'b0;
      case (state_reg)
        S_POWERUP: begin
          if (pwr_cnt_reg == CW'(POWERUP_CYC - 1)) begin
            state_reg   <= S_INIT_NIB;
            pwr_cnt_reg <= '0;
          end else begin
            pwr_cnt_reg <= pwr_cnt_reg + CW'(1);
          end
        end
        S_INIT_NIB: begin
          if (!pending_reg && !wr_busy) begin
            wr_start_reg    <= 1'b1;
            wr_byte_reg     <= (step_reg == 2'd3) ? 8'h20 : 8'h30;
            wr_rs_reg       <= 1'b0;
            wr_nib_only_reg <= 1'b1;
            pending_reg     <= 1'b1;
          end else if (wr_done) begin
            pending_reg <= 1'b0;
            step_reg    <= step_reg + 2'd1;
            if (step_reg == 2'd3) state_reg <= S_INIT_CMD;
          end
        end
        S_INIT_CMD: begin
          if (!pending_reg && !wr_busy) begin
            wr_start_reg    <= 1'b1;
            wr_byte_reg     <= init_cmd(step_reg);
            wr_rs_reg       <= 1'b0;
            wr_nib_only_reg <= 1'b0;
            pending_reg     <= 1'b1;
          end else if (wr_done) begin
            pending_reg <= 1'b0;
            step_reg    <= step_reg + 2'd1;
            if (step_reg == 2'd3) state_reg <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (!snapped_reg) begin
`ifdef LCD_DIRTY_SKIP_EN
            if (frame_sent_reg && row_A == snap_a_reg && row_B == snap_b_reg) begin
              state_reg <= S_IDLE;
            end else begin
              snap_a_reg  <= row_A;
              snap_b_reg  <= row_B;
              snapped_reg <= 1'b1;
            end
`else
            snap_a_reg  <= row_A;
            snap_b_reg  <= row_B;
            snapped_reg <= 1'b1;
`endif
          end else if (!pending_reg && !wr_busy) begin
            wr_start_reg    <= 1'b1;
            wr_byte_reg     <= frame_byte;
            wr_rs_reg       <= frame_rs;
            wr_nib_only_reg <= 1'b0;
            pending_reg     <= 1'b1;
          end else if (wr_done) begin
            pending_reg <= 1'b0;
            if (!data_phase_reg) begin
              data_phase_reg <= 1'b1;
            end else begin
              col_reg <= col_reg + 4'd1;
              if (col_reg == 4'd15) begin
                data_phase_reg <= 1'b0;
                row_sel_reg    <= ~row_sel_reg;
                if (row_sel_reg) begin
                  frame_done  <= 1'b1;
                  snapped_reg <= 1'b0;
`ifdef LCD_DIRTY_SKIP_EN
                  frame_sent_reg <= 1'b1;
`endif
                end
              end
            end
          end
        end
        S_IDLE:  state_reg <= S_FRAME;
        default: state_reg <= S_POWERUP;
      endcase
    end
  end

  lcd_byte_writer #(
    .POWERUP_CYC      (POWERUP_CYC),
    .INIT_NIB_WAIT_CYC(INIT_NIB_WAIT_CYC),
    .E_PULSE_CYC      (E_PULSE_CYC),
    .NIBBLE_GAP_CYC   (NIBBLE_GAP_CYC),
    .CMD_WAIT_CYC     (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC   (CLEAR_WAIT_CYC)
  ) u_writer (
    .clk_50MHz  (clk_50MHz),
    .reset_n    (reset_n),
    .start      (wr_start_reg),
    .data_byte  (wr_byte_reg),
    .rs         (wr_rs_reg),
    .nibble_only(wr_nib_only_reg),
    .busy       (wr_busy),
    .done       (wr_done),
    .lcd_e      (LCD_E),
    .lcd_rs     (LCD_RS),
    .lcd_d      (LCD_D)
  );

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench for lcd_text_driver: expected nibbles are queued as stimulus is
// decided and popped on every E falling edge, alongside bus timing checks.
module tb_lcd_text_driver;

  logic         clk_50MHz = 1'b0;
  logic         reset_n   = 1'b0;
  logic [127:0] row_A     = '0;
  logic [127:0] row_B     = '0;
  logic         LCD_E;
  logic         LCD_RS;
  logic         LCD_RW;
  logic [3:0]   LCD_D;
  logic         frame_done;

  lcd_text_driver #(
    .POWERUP_CYC      (100),
    .INIT_NIB_WAIT_CYC(40),
    .E_PULSE_CYC      (2),
    .NIBBLE_GAP_CYC   (2),
    .CMD_WAIT_CYC     (10),
    .CLEAR_WAIT_CYC   (50)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .row_A     (row_A),
    .row_B     (row_B),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_D     (LCD_D),
    .frame_done(frame_done)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int nib_cnt = 0;
  int frame_nibs = 0;
  int done_cnt = 0;
  int e_rises = 0;
  int e_cnt = 0;
  int last_fall_cyc = 0;
  bit mon_en = 1'b0;
  bit first_rise_seen = 1'b0;
  bit first_frame = 1'b1;
  bit clr_pending = 1'b0;
  logic       prev_e = 1'b0;
  logic       prev_rs = 1'b0;
  logic [3:0] prev_d = '0;
  logic [5:0] exp_q[$];   // {gap-after-clear flag, rs, nibble}
  logic [5:0] exp_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int obs, input int lim);
    checks++;
    assert (obs >= lim) else begin
      errors++;
      $error("FAIL %s observed=%0d expected>=%0d", tag, obs, lim);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rs);
    exp_q.push_back({1'b0, rs, b[7:4]});
    exp_q.push_back({(rs == 1'b0 && b == 8'h01), rs, b[3:0]});
  endtask

  task automatic push_init();
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, (i == 3) ? 4'h2 : 4'h3});
    push_byte(8'h28, 1'b0);
    push_byte(8'h0C, 1'b0);
    push_byte(8'h06, 1'b0);
    push_byte(8'h01, 1'b0);
  endtask

  task automatic push_frame(input logic [127:0] a, input logic [127:0] bb);
    push_byte(8'h80, 1'b0);
    for (int c = 0; c < 16; c++) push_byte(a[(15 - c) * 8 +: 8], 1'b1);
    push_byte(8'hC0, 1'b0);
    for (int c = 0; c < 16; c++) push_byte(bb[(15 - c) * 8 +: 8], 1'b1);
  endtask

  task automatic wait_nibs(input int target, input int budget);
    int n = 0;
    while (nib_cnt < target && n < budget) begin
      @(posedge clk_50MHz); #1;
      n++;
    end
    check_ge("nibble_wait", nib_cnt, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk_50MHz); #1;
      n++;
    end
    check_ge("frame_done_wait", done_cnt, target);
  endtask

  task automatic release_reset();
    reset_n         = 1'b1;
    rel_cyc         = cyc;
    first_rise_seen = 1'b0;
    first_frame     = 1'b1;
    mon_en          = 1'b1;
  endtask

  // Bus monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk_50MHz) begin
    cyc++;
    if (mon_en) begin
      check("rw_low", LCD_RW, 1'b0);
      if (LCD_E && !prev_e) begin
        e_cnt = 1;
        e_rises++;
        check("setup_stable", {LCD_RS, LCD_D}, {prev_rs, prev_d});
        if (!first_rise_seen) begin
          first_rise_seen = 1'b1;
          check_ge("powerup_wait", cyc - rel_cyc, 100);
        end
        if (clr_pending) begin
          check_ge("clear_gap", cyc - last_fall_cyc, 50);
          clr_pending = 1'b0;
        end
      end else if (LCD_E && prev_e) begin
        e_cnt++;
        check("ehi_stable", {LCD_RS, LCD_D}, {prev_rs, prev_d});
      end else if (!LCD_E && prev_e) begin
        check("e_width", e_cnt, 2);
        check("hold_stable", {LCD_RS, LCD_D}, {prev_rs, prev_d});
        check_ge("nibble_queued", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          exp_n = exp_q.pop_front();
          check("nibble", {LCD_RS, LCD_D}, exp_n[4:0]);
          clr_pending = exp_n[5];
        end
        last_fall_cyc = cyc;
        nib_cnt++;
        frame_nibs++;
      end
      if (frame_done) begin
        check("frame_nibbles", frame_nibs, first_frame ? 80 : 68);
        $display("frame %0d done at cycle %0d", done_cnt + 1, cyc);
        frame_nibs  = 0;
        first_frame = 1'b0;
        done_cnt++;
      end
    end else begin
      clr_pending = 1'b0;
    end
    prev_e  = LCD_E;
    prev_rs = LCD_RS;
    prev_d  = LCD_D;
  end

  initial begin
    logic [127:0] ra_hello;
    logic [127:0] ra_j;
    logic [127:0] rb;
    logic [127:0] rb2;
    int n;
    int er;
    ra_hello = "HELLO WORLD 1234";
    rb       = "SCORE 00FF      ";
    ra_j     = ra_hello;
    ra_j[127:120] = "J";
    row_A   = ra_hello;
    row_B   = rb;
    reset_n = 1'b0;
    repeat (5) @(posedge clk_50MHz);
    #1;
    check("rst_e", LCD_E, 1'b0);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_d", LCD_D, 4'h0);
    check("rst_rw", LCD_RW, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    // Frame 1 keeps the old text; column 0 changes to 'J' mid-frame.
    push_init();
    push_frame(ra_hello, rb);
    push_frame(ra_j, rb);
    release_reset();
    wait_nibs(25, 5000);
    row_A = ra_j;
    $display("row_A col0 -> J at cycle %0d", cyc);
    wait_done(1, 5000);
    check("queue_after_frame1", exp_q.size(), 68);

    // Reset while E is high, partway into frame 2.
    wait_nibs(12 + 68 + 10, 5000);
    n = 0;
    while (!LCD_E && n < 200) begin
      @(posedge clk_50MHz); #1;
      n++;
    end
    check("e_high_before_reset", LCD_E, 1'b1);
    reset_n = 1'b0;
    mon_en  = 1'b0;
    @(posedge clk_50MHz); #1;
    check("reset_e_drop", LCD_E, 1'b0);
    check("reset_d_clear", LCD_D, 4'h0);
    check("reset_frame_done", frame_done, 1'b0);
    repeat (3) @(posedge clk_50MHz);
    #1;
    exp_q.delete();
    nib_cnt    = 0;
    frame_nibs = 0;
    done_cnt   = 0;
    push_init();
    push_frame(ra_j, rb);
    release_reset();
    $display("reset released at cycle %0d", cyc);
    wait_done(1, 5000);
    check("queue_after_reset_frame", exp_q.size(), 0);

`ifdef LCD_DIRTY_SKIP_EN
    er = e_rises;
    repeat (10000) @(posedge clk_50MHz);
    #1;
    check("skip_no_e", e_rises, er);
    check("skip_no_frame", done_cnt, 1);
    rb2 = rb;
    rb2[7:0] = "!";
    row_B = rb2;
    push_frame(ra_j, rb2);
    wait_done(2, 5000);
    repeat (2000) @(posedge clk_50MHz);
    #1;
    check("skip_one_more_frame", done_cnt, 2);
    check("skip_queue_empty", exp_q.size(), 0);
`else
    er  = e_rises;
    rb2 = rb;
    push_frame(ra_j, rb2);
    wait_done(2, 5000);
    check("refresh_queue_empty", exp_q.size(), 0);
    check_ge("refresh_e_pulses", e_rises - er, 68);
`endif

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
